dot_product_accumulator: RTL and testbench
==========================================

Name: dot_product_accumulator

Overview:
Downstream consumer of the 4x4 array multiplier's 8-bit product.
- Sums VEC_LEN consecutive products into one dot-product result.
- Valid/ready handshake on both sides; the result is held until taken.
- Sits between the multiplier and the result-collection logic of the MAC datapath.

Parameters:
VEC_LEN, 16, number of products per dot product (>=2)
PROD_W, 8, product width (matches multiplier output z)
ACC_W, 12, accumulator/result width (default holds 16*225=3600 without overflow)
CNT_W, $clog2(VEC_LEN+1), beat-count width

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  product beat present
in_ready  output  1  block can accept a beat this cycle
in_prod  input  PROD_W  unsigned product from multiplier
flush  input  1  terminate current vector early, emit partial sum
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_sum  output  ACC_W  accumulated dot product
out_count  output  CNT_W  number of products in out_sum
out_ovf  output  1  sum exceeded ACC_W range (sticky per vector)

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- Reset:
  - state=ACCUM; acc=0; cnt=0; ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
  - rst overrides all other inputs, including mid-vector and during HOLD: the result is discarded and the partial sum is lost.
- FSM states: ACCUM, HOLD.
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1; out_sum, out_count and out_ovf are registered and stable until the handshake completes.
- Accept: beat accepted when in_valid&&in_ready.
  - acc <= acc + zero-extended in_prod.
  - cnt <= cnt+1.
  - ovf set if the carry out of ACC_W is 1.
- Completion: when the accepted beat makes cnt==VEC_LEN, next cycle is HOLD with out_sum=final sum and out_count=VEC_LEN.
  - Latency: last accepted beat to out_valid = 1 cycle.
- Flush in ACCUM:
  - Next cycle is HOLD with out_sum=acc (including any beat accepted the same cycle) and out_count=cnt (likewise).
  - Flush with cnt==0 and no beat accepted still emits a result with sum=0, count=0.
- Flush in HOLD: ignored.
- Output handshake: out_valid&&out_ready in HOLD moves to ACCUM next cycle, with acc=0, cnt=0, ovf=0.
  - No beat is accepted in the handover cycle (in_ready is 0 in HOLD): one bubble per vector.
  - out_sum, out_count and out_ovf keep their last values after the handshake; only out_valid drops.
- in_prod is ignored when in_valid=0 or in_ready=0; an unaccepted beat must be held by the producer.
- Default overflow behaviour: acc wraps modulo 2^ACC_W; out_ovf reports the wrap.

Optional Feature:
Macro: DOT_ACC_SAT_EN
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the vector; out_ovf still set.
- Undefined: wrap-around arithmetic as above.
- Handshake timing is identical in both builds.

Decomposition:
- Package dot_acc_pkg:
  - state enum (ST_ACCUM, ST_HOLD);
  - default constants DOT_VEC_LEN=16, DOT_PROD_W=8, DOT_ACC_W=12.
- Sub-module: sat_add_unit, a combinational ACC_W adder with carry/overflow and the DOT_ACC_SAT_EN clamp; instantiated once.
- FSM, counter and output registers stay in the top module.

Test Plan:
- Reset then 16 beats of in_prod=225, out_ready=1:
  - out_valid 1 cycle after the 16th beat;
  - out_sum=3600, out_count=16, out_ovf=0;
  - in_ready=0 for exactly 1 cycle.
- 5 beats of in_prod=10 then flush=1 with a 6th beat (in_prod=7) in the same cycle:
  - out_sum=57, out_count=6.
- Backpressure: out_ready=0 for 4 cycles in HOLD with in_valid=1:
  - in_ready stays 0;
  - out_sum stable;
  - no beats lost after release (next vector sums correctly).
- Overflow with ACC_W=8, VEC_LEN=4, products 200,100,1,1:
  - default build: out_sum=46 (302 mod 256), out_ovf=1;
  - with DOT_ACC_SAT_EN: out_sum=255, out_ovf=1.
- rst asserted after 3 beats, and again during HOLD:
  - next cycle out_valid=0, in_ready=1;
  - the following full vector of in_prod=1 gives out_sum=16.
- Flush with cnt=0, in_valid=0:
  - out_sum=0, out_count=0, out_valid=1 the next cycle.

Source files
------------

// File: rtl/dot_product_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dot_acc_pkg
//  Description : Shared types and default sizing for the dot-product
//                accumulator (state encoding, vector/product/accumulator
//                widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package dot_acc_pkg;

    // Two-state control: collecting beats, or presenting a finished result.
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int DOT_VEC_LEN = 16;
    localparam int DOT_PROD_W  = 8;
    localparam int DOT_ACC_W   = 12;

endpackage : dot_acc_pkg
`default_nettype wire

// File: rtl/dot_product_accumulator_sat_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : sat_add_unit
//  Description : Combinational ACC_W-bit adder of an accumulator and a
//                zero-extended product. Reports the carry out of ACC_W.
//                Build option DOT_ACC_SAT_EN: on carry the sum clamps to
//                2^ACC_W-1 instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_add_unit #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    // One extra bit captures the carry; the product is zero-extended by the
    // width cast so PROD_W == ACC_W needs no special case.
    logic [ACC_W:0] w_full;

    assign w_full = {1'b0, acc} + (ACC_W+1)'(prod);
    assign carry  = w_full[ACC_W];

`ifdef DOT_ACC_SAT_EN
    // A clamped accumulator stays clamped: any further nonzero product
    // carries again and re-clamps, a zero product leaves it at full scale.
    assign sum = carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign sum = w_full[ACC_W-1:0];
`endif

endmodule : sat_add_unit
`default_nettype wire

// File: rtl/dot_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : dot_product_accumulator
//  Description : Sums VEC_LEN consecutive unsigned products into one
//                dot-product result with valid/ready on both sides. An early
//                flush emits the partial sum. The result is held until the
//                consumer takes it (one bubble per vector).
//                Build option DOT_ACC_SAT_EN: saturating instead of wrapping
//                accumulation (out_ovf reported in both builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module dot_product_accumulator
    import dot_acc_pkg::*;
#(
    parameter int VEC_LEN = DOT_VEC_LEN,
    parameter int PROD_W  = DOT_PROD_W,
    parameter int ACC_W   = DOT_ACC_W,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] C_VEC_LEN = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic               w_accept;
    logic [ACC_W-1:0]   w_add_sum;
    logic               w_add_carry;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_ovf_next;
    logic               w_done;

    sat_add_unit #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .acc    (r_acc),
        .prod   (in_prod),
        .sum    (w_add_sum),
        .carry  (w_add_carry)
    );

    // Running values including this cycle's beat, so a flush or completion
    // in the same cycle as a beat captures that beat too.
    always_comb begin
        w_accept   = in_valid && r_in_ready;
        w_acc_next = r_acc;
        w_cnt_next = r_cnt;
        w_ovf_next = r_ovf;
        if (w_accept) begin
            w_acc_next = w_add_sum;
            w_cnt_next = r_cnt + C_CNT_ONE;
            w_ovf_next = r_ovf | w_add_carry;
        end
        w_done = w_accept && (w_cnt_next == C_VEC_LEN);
    end

    // Control FSM with accumulator, beat counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_next;
                    r_ovf <= w_ovf_next;
                    if (w_done || flush) begin
                        r_state     <= ST_HOLD;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_sum   <= w_acc_next;
                        r_out_count <= w_cnt_next;
                        r_out_ovf   <= w_ovf_next;
                    end
                end
                ST_HOLD: begin
                    // Flush is ignored here; only the consumer releases us.
                    if (out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule : dot_product_accumulator
`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_product_accumulator
//  Description : Self-checking bench for dot_product_accumulator: vector
//                table, hand-written corner sequences, randomized vectors
//                against a queue-based sum model, and a narrow instance
//                (ACC_W=8, VEC_LEN=4) for overflow/saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_prod;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [4:0]  out_count;
    logic        out_ovf;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_prod;
    logic        s_flush;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_sum;
    logic [2:0]  s_out_count;
    logic        s_out_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dot_product_accumulator #(
        .VEC_LEN (16),
        .PROD_W  (8),
        .ACC_W   (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    dot_product_accumulator #(
        .VEC_LEN (4),
        .PROD_W  (8),
        .ACC_W   (8)
    ) dut_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_prod   (s_in_prod),
        .flush     (s_flush),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sum   (s_out_sum),
        .out_count (s_out_count),
        .out_ovf   (s_out_ovf)
    );

    typedef struct {
        int prod;
        int last_prod;
        int nbeats;
        bit flush_last;
        int exp_sum;
        int exp_cnt;
        bit exp_ovf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted (bounded).
    task automatic send_beat(input int p, input bit fl);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_prod  = 8'(p);
        flush    = fl;
        while (!in_ready && w < 100) begin
            step();
            w++;
        end
        if (!in_ready) chk("beat_accept_timeout", 0, 1);
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_prod  = 8'($urandom);
    endtask

    // Wait for a result, check it, optionally stall, then take it.
    task automatic wait_result(input string name, input int es, input int ec,
                               input int eo, input int stall);
        int w;
        w = 0;
        while (!out_valid && w < 100) begin
            step();
            w++;
        end
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_sum"}, int'(out_sum), es);
        chk({name, "_count"}, int'(out_count), ec);
        chk({name, "_ovf"}, int'(out_ovf), eo);
        chk({name, "_in_ready_hold"}, int'(in_ready), 0);
        for (int i = 0; i < stall; i++) begin
            step();
            chk({name, "_stall_sum"}, int'(out_sum), es);
            chk({name, "_stall_valid"}, int'(out_valid), 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, int'(out_valid), 0);
        chk({name, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        vec_t tbl[6];
        int   q[$];
        int   total;
        int   len;
        int   sp[4];
        int   held_sum;

        tbl[0] = '{225, 225, 16, 1'b0, 3600, 16, 1'b0};
        tbl[1] = '{10,  7,   6,  1'b1, 57,   6,  1'b0};
        tbl[2] = '{255, 255, 16, 1'b0, 4080, 16, 1'b0};
        tbl[3] = '{0,   0,   16, 1'b0, 0,    16, 1'b0};
        tbl[4] = '{1,   100, 3,  1'b1, 102,  3,  1'b0};
        tbl[5] = '{4,   9,   1,  1'b1, 9,    1,  1'b0};

        rst = 1'b1; in_valid = 1'b0; in_prod = '0; flush = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_prod = '0; s_flush = 1'b0; s_out_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);

        // First vector: result visible right after the 16th beat, one bubble.
        for (int i = 0; i < 16; i++) send_beat(225, 1'b0);
        chk("lat_out_valid", int'(out_valid), 1);
        chk("lat_in_ready", int'(in_ready), 0);
        wait_result("full225", 3600, 16, 0, 0);

        // Table-driven vectors
        for (int t = 0; t < 6; t++) begin
            for (int b = 0; b < tbl[t].nbeats; b++) begin
                if (b == tbl[t].nbeats - 1)
                    send_beat(tbl[t].last_prod, tbl[t].flush_last);
                else
                    send_beat(tbl[t].prod, 1'b0);
            end
            wait_result($sformatf("tbl%0d", t), tbl[t].exp_sum, tbl[t].exp_cnt,
                        int'(tbl[t].exp_ovf), t % 3);
        end

        // Flush with nothing accumulated
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush0_valid_next", int'(out_valid), 1);
        wait_result("flush0", 0, 0, 0, 0);

        // Backpressure with a beat waiting, then the waiting beat is kept.
        for (int i = 0; i < 16; i++) send_beat(2, 1'b0);
        held_sum = 32;
        in_valid = 1'b1;
        in_prod  = 8'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_sum_stable", int'(out_sum), held_sum);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("bp_flush_ignored_count", int'(out_count), 16);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_released", int'(in_ready), 1);
        chk("bp_last_sum_kept", int'(out_sum), held_sum);
        for (int i = 0; i < 16; i++) send_beat(3, 1'b0);
        wait_result("bp_next", 48, 16, 0, 0);

        // Reset mid-vector
        for (int i = 0; i < 3; i++) send_beat(50, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_valid", int'(out_valid), 0);
        chk("rstmid_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 16; i++) send_beat(1, 1'b0);
        wait_result("rstmid_next", 16, 16, 0, 0);

        // Reset during HOLD discards the result
        for (int i = 0; i < 16; i++) send_beat(7, 1'b0);
        chk("rsthold_in_hold", int'(out_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rsthold_valid", int'(out_valid), 0);
        chk("rsthold_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 16; i++) send_beat(1, 1'b0);
        wait_result("rsthold_next", 16, 16, 0, 0);

        // Randomized vectors against a queue-based sum model
        for (int v = 0; v < 25; v++) begin
            q.delete();
            len = (($urandom & 32'h3) == 0) ? int'($urandom_range(1, 15)) : 16;
            for (int b = 0; b < len; b++) begin
                int p;
                if (($urandom & 32'h3) == 0) begin
                    in_prod = 8'($urandom);
                    step();
                end
                p = int'($urandom_range(0, 255));
                q.push_back(p);
                send_beat(p, (len < 16) && (b == len - 1));
            end
            total = 0;
            foreach (q[k]) total += q[k];
            wait_result($sformatf("rand%0d", v), total % 4096, q.size(),
                        (total >= 4096) ? 1 : 0, int'($urandom_range(0, 3)));
        end

        // Narrow instance: 200+100+1+1 = 302 overflows 8 bits
        sp[0] = 200; sp[1] = 100; sp[2] = 1; sp[3] = 1;
        chk("small_in_ready", int'(s_in_ready), 1);
        s_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_in_prod = 8'(sp[i]);
            step();
        end
        s_in_valid = 1'b0;
        chk("small_valid", int'(s_out_valid), 1);
        chk("small_count", int'(s_out_count), 4);
        chk("small_ovf", int'(s_out_ovf), 1);
`ifdef DOT_ACC_SAT_EN
        chk("small_sum_sat", int'(s_out_sum), 255);
`else
        chk("small_sum_wrap", int'(s_out_sum), 46);
`endif
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        chk("small_valid_drop", int'(s_out_valid), 0);
        chk("small_ovf_kept", int'(s_out_ovf), 1);

        // Overflow flag clears for the next vector
        s_in_valid = 1'b1;
        s_in_prod  = 8'd5;
        for (int i = 0; i < 4; i++) step();
        s_in_valid = 1'b0;
        chk("small2_sum", int'(s_out_sum), 20);
        chk("small2_ovf", int'(s_out_ovf), 0);
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dot_product_accumulator
`default_nettype wire
